// File: rtl/wf_inflight_tracker.sv
// Per-wavefront in-flight instruction counters with busy/full flags, a running
// total, and a single registered error report per cycle.
module wf_inflight_tracker #(
    parameter int NUM_WF = 40,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [5:0]        issue_wfid,
    input  logic              done_valid,
    input  logic [5:0]        done_wfid,
    input  logic              clear_valid,
    input  logic [5:0]        clear_wfid,
    output logic [NUM_WF-1:0] wf_busy,
    output logic [NUM_WF-1:0] wf_full,
    output logic [9:0]        total_inflight,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [5:0]        err_wfid
);

    localparam logic [6:0]       NUM_WF_L = 7'(NUM_WF);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [1:0]       ERR_NONE = 2'd0;
    localparam logic [1:0]       ERR_UNF  = 2'd1;
    localparam logic [1:0]       ERR_OVF  = 2'd2;
    localparam logic [1:0]       ERR_BAD  = 2'd3;

    logic [CNT_W-1:0]  cnt_r     [NUM_WF];
    logic [CNT_W-1:0]  cnt_nxt_s [NUM_WF];
    logic [9:0]        total_r;
    logic [9:0]        total_nxt_s;
    logic [9:0]        tot_add_s;
    logic [9:0]        tot_sub_s;
    logic              issue_ok_s, done_ok_s, clear_ok_s;
    logic              issue_bad_s, done_bad_s, clear_bad_s;
    logic [NUM_WF-1:0] issue_hit_s, done_hit_s, clear_hit_s;
    logic              ovf_s, unf_s;
    logic              err_valid_nxt_s;
    logic [1:0]        err_code_nxt_s;
    logic [5:0]        err_wfid_nxt_s;

    // Qualify each event; wfids are only looked at when their valid is set.
    always_comb begin
        issue_ok_s  = 1'b0;
        issue_bad_s = 1'b0;
        done_ok_s   = 1'b0;
        done_bad_s  = 1'b0;
        clear_ok_s  = 1'b0;
        clear_bad_s = 1'b0;
        if (issue_valid) begin
            issue_ok_s  = ({1'b0, issue_wfid} < NUM_WF_L);
            issue_bad_s = !({1'b0, issue_wfid} < NUM_WF_L);
        end else begin
            issue_ok_s  = 1'b0;
        end
        if (done_valid) begin
            done_ok_s  = ({1'b0, done_wfid} < NUM_WF_L);
            done_bad_s = !({1'b0, done_wfid} < NUM_WF_L);
        end else begin
            done_ok_s  = 1'b0;
        end
        if (clear_valid) begin
            clear_ok_s  = ({1'b0, clear_wfid} < NUM_WF_L);
            clear_bad_s = !({1'b0, clear_wfid} < NUM_WF_L);
        end else begin
            clear_ok_s  = 1'b0;
        end
    end

    // One-hot decode of each legal event onto the slot it targets.
    always_comb begin
        issue_hit_s = {NUM_WF{1'b0}};
        done_hit_s  = {NUM_WF{1'b0}};
        clear_hit_s = {NUM_WF{1'b0}};
        for (int n = 0; n < NUM_WF; n++) begin
            issue_hit_s[n] = issue_ok_s && (issue_wfid == 6'(n));
            done_hit_s[n]  = done_ok_s  && (done_wfid  == 6'(n));
            clear_hit_s[n] = clear_ok_s && (clear_wfid == 6'(n));
        end
    end

    // Per-slot next count; clear wins, and a matched issue+done cancels out.
    always_comb begin
        tot_add_s = 10'd0;
        tot_sub_s = 10'd0;
        ovf_s     = 1'b0;
        unf_s     = 1'b0;
        for (int n = 0; n < NUM_WF; n++) begin
            cnt_nxt_s[n] = cnt_r[n];
            if (clear_hit_s[n]) begin
                tot_sub_s = tot_sub_s + {{(10-CNT_W){1'b0}}, cnt_r[n]};
                if (issue_hit_s[n]) begin
                    cnt_nxt_s[n] = CNT_ONE;
                    tot_add_s    = tot_add_s + 10'd1;
                end else begin
                    cnt_nxt_s[n] = CNT_ZERO;
                end
            end else if (issue_hit_s[n] && done_hit_s[n]) begin
                cnt_nxt_s[n] = cnt_r[n];
            end else if (issue_hit_s[n]) begin
                if (cnt_r[n] == CNT_MAX) begin
                    ovf_s = 1'b1;
                end else begin
                    cnt_nxt_s[n] = cnt_r[n] + CNT_ONE;
                    tot_add_s    = tot_add_s + 10'd1;
                end
            end else if (done_hit_s[n]) begin
                if (cnt_r[n] == CNT_ZERO) begin
                    unf_s = 1'b1;
                end else begin
                    cnt_nxt_s[n] = cnt_r[n] - CNT_ONE;
                    tot_sub_s    = tot_sub_s + 10'd1;
                end
            end else begin
                cnt_nxt_s[n] = cnt_r[n];
            end
        end
        total_nxt_s = total_r + tot_add_s - tot_sub_s;
    end

    // Pick the single error to report: bad wfid, then underflow, then overflow.
    always_comb begin
        err_valid_nxt_s = 1'b0;
        err_code_nxt_s  = ERR_NONE;
        err_wfid_nxt_s  = 6'd0;
        if (issue_bad_s) begin
            err_valid_nxt_s = 1'b1;
            err_code_nxt_s  = ERR_BAD;
            err_wfid_nxt_s  = issue_wfid;
        end else if (done_bad_s) begin
            err_valid_nxt_s = 1'b1;
            err_code_nxt_s  = ERR_BAD;
            err_wfid_nxt_s  = done_wfid;
        end else if (clear_bad_s) begin
            err_valid_nxt_s = 1'b1;
            err_code_nxt_s  = ERR_BAD;
            err_wfid_nxt_s  = clear_wfid;
        end else if (unf_s) begin
            err_valid_nxt_s = 1'b1;
            err_code_nxt_s  = ERR_UNF;
            err_wfid_nxt_s  = done_wfid;
        end else if (ovf_s) begin
            err_valid_nxt_s = 1'b1;
            err_code_nxt_s  = ERR_OVF;
            err_wfid_nxt_s  = issue_wfid;
        end else begin
            err_valid_nxt_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_WF; n++) begin
                cnt_r[n] <= CNT_ZERO;
            end
            wf_busy   <= {NUM_WF{1'b0}};
            wf_full   <= {NUM_WF{1'b0}};
            total_r   <= 10'd0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            err_wfid  <= 6'd0;
        end else begin
            for (int n = 0; n < NUM_WF; n++) begin
                cnt_r[n]   <= cnt_nxt_s[n];
                wf_busy[n] <= (cnt_nxt_s[n] != CNT_ZERO);
                wf_full[n] <= (cnt_nxt_s[n] == CNT_MAX);
            end
            total_r   <= total_nxt_s;
            err_valid <= err_valid_nxt_s;
            err_code  <= err_code_nxt_s;
            err_wfid  <= err_wfid_nxt_s;
        end
    end

    assign total_inflight = total_r;

endmodule

// File: doc/wf_inflight_tracker.md
WF_INFLIGHT_TRACKER -- requirements
Module: wf_inflight_tracker

Interface
REQ-001 SHALL provide parameter NUM_WF, default 40, number of tracked wavefront slots (legal wfid 0..NUM_WF-1).
REQ-002 SHALL provide parameter CNT_W, default 4, width of each per-wavefront in-flight counter (max 2^CNT_W-1 = 15).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port issue_valid  input  1  one instruction issued this cycle.
REQ-006 SHALL have port issue_wfid  input  6  wavefront of issued instruction.
REQ-007 SHALL have port done_valid  input  1  completion strobe, driven by the writeback wfid mux output muxed_wfid_done.
REQ-008 SHALL have port done_wfid  input  6  completing wavefront, driven by muxed_wfid; don't-care when done_valid=0 (may be X).
REQ-009 SHALL have port clear_valid  input  1  wavefront retired/flushed, zero its counter.
REQ-010 SHALL have port clear_wfid  input  6  wavefront to clear.
REQ-011 SHALL have port wf_busy  output  NUM_WF  bit n = counter[n] != 0.
REQ-012 SHALL have port wf_full  output  NUM_WF  bit n = counter[n] == 15.
REQ-013 SHALL have port total_inflight  output  10  sum of all counters.
REQ-014 SHALL have ports err_valid (1), err_code (2), err_wfid (6) as outputs: registered one-cycle error report.

Function
REQ-015 SHALL hold one CNT_W-bit counter per wavefront; all outputs are registered and reflect events of cycle N on cycle N+1.
REQ-016 SHALL, on issue_valid with legal wfid, increment that counter, unless it is 15: counter held, overflow error raised (code 2).
REQ-017 SHALL, on done_valid with legal wfid, decrement that counter, unless it is 0: counter held, underflow error raised (code 1).
REQ-018 SHALL, when issue and done target the same wfid in one cycle, leave that counter unchanged and raise no overflow/underflow, including at counts 0 and 15.
REQ-019 SHALL, on clear_valid, set the cleared counter to 0; same-cycle done on that wfid is ignored without error; same-cycle issue on that wfid makes the counter 1.
REQ-020 SHALL ignore any valid event with wfid >= NUM_WF, with no counter change, and raise bad-wfid error (code 3) carrying that wfid.
REQ-021 SHALL never sample done_wfid, issue_wfid or clear_wfid when the matching valid is 0; X on them then has no effect.
REQ-022 SHALL keep total_inflight equal to the sum of counters every cycle: +1 per accepted increment, -1 per accepted decrement, minus the prior count on clear.
REQ-023 SHALL raise err_valid for exactly one cycle per errored input cycle; when several errors occur at once, report one, priority code 3 > code 1 > code 2; the lowest-priority errors are dropped.
REQ-024 SHALL, when err_valid=0, drive err_code=0 and err_wfid=0.
REQ-025 SHALL process events for different wfids in the same cycle independently.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, zero all counters, wf_busy, wf_full, total_inflight, err_valid, err_code and err_wfid, ignoring all same-cycle events.
REQ-027 SHALL, on reset asserted mid-operation, discard all in-flight counts; the first event after rst deasserts is counted from 0.

Verification
REQ-028 SHALL pass: reset, then issue wfid 5 three times, then done wfid 5 once -> counter 2, wf_busy[5]=1, total_inflight=2.
REQ-029 SHALL pass: 16 issues to wfid 39 -> after the 15th, wf_full[39]=1; on the 16th, err_valid=1, err_code=2, err_wfid=39, count stays 15.
REQ-030 SHALL pass: done wfid 7 at count 0 -> err_valid=1 for one cycle, code 1, wfid 7, total unchanged; repeat with issue+done on wfid 7 same cycle -> no error, count 0.
REQ-031 SHALL pass: issue wfid 45 -> err code 3, err_wfid=45, no counter or total change; done_valid=0 with done_wfid=X for 10 cycles -> no change.
REQ-032 SHALL pass: wfid 2 at count 4, total 6; clear wfid 2 with same-cycle issue wfid 2 -> count 1, total 3.
REQ-033 SHALL pass: counts loaded on several wfids, rst pulsed one cycle -> all outputs 0 on the next cycle.
